reg_file_sb: RTL and testbench

//  Parametrised dual-write register file with load scoreboard for KGP-miniRISC gen-2.
//  - Two combinational read ports with same-cycle write bypass.
//  - Write port W0: ALU/link write-back. Write port W1: late load-return.
//  - Per-register busy bits track outstanding loads; bounded pending counter

---
 rtl/reg_file_sb.sv | 105 ++++++++++
 tb/tb_reg_file_sb.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Dual-write register file with zero-latency read bypass and a load scoreboard.
// Optional feature: define RF_ZERO_REG_EN to hard-wire register 0 to zero.
module reg_file_sb #(
  parameter int unsigned  DATA_W   = 32,
  parameter int unsigned  ADDR_W   = 5,
  parameter int unsigned  LINK_REG = 31,
  parameter int unsigned  MAX_PEND = 4,
  localparam int unsigned NUM_REGS = 2 ** ADDR_W,
  localparam int unsigned CW       = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              w0_en,
  input  logic              w0_link,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_dst,
  input  logic              w1_en,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  output logic              hazard,
  output logic              pend_full,
  output logic [CW-1:0]     pend_cnt
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                full_q, full_d;

  logic [ADDR_W-1:0] w0_eff;
  logic              w0_we, w1_we, issue_acc, ret_vld;

  // Write qualification and scoreboard events
  always_comb begin
    w0_eff    = w0_link ? ADDR_W'(LINK_REG) : w0_addr;
`ifdef RF_ZERO_REG_EN
    w0_we     = w0_en & (w0_eff != '0);
    w1_we     = w1_en & (w1_addr != '0);
    issue_acc = ld_issue & ~full_q & (ld_dst != '0);
`else
    w0_we     = w0_en;
    w1_we     = w1_en;
    issue_acc = ld_issue & ~full_q;
`endif
    ret_vld   = w1_en & busy_q[w1_addr];
  end

  // Read ports: W1 bypass beats W0 bypass beats stored value
  always_comb begin
    ra_data = regs_q[ra_addr];
    rb_data = regs_q[rb_addr];
    if (w0_we && (w0_eff == ra_addr))  ra_data = w0_data;
    if (w0_we && (w0_eff == rb_addr))  rb_data = w0_data;
    if (w1_we && (w1_addr == ra_addr)) ra_data = w1_data;
    if (w1_we && (w1_addr == rb_addr)) rb_data = w1_data;
`ifdef RF_ZERO_REG_EN
    if (ra_addr == '0) ra_data = '0;
    if (rb_addr == '0) rb_data = '0;
`endif
  end

  // Scoreboard next state; a same-cycle issue re-owns a register being returned
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (ret_vld)   busy_d[w1_addr] = 1'b0;
    if (issue_acc) busy_d[ld_dst]  = 1'b1;
    if (issue_acc && !ret_vld && (cnt_q != CW'(MAX_PEND))) cnt_d = cnt_q + CW'(1);
    else if (ret_vld && !issue_acc && (cnt_q != '0))        cnt_d = cnt_q - CW'(1);
    full_d = (cnt_d == CW'(MAX_PEND));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  // Register array; W1 assigned last so it wins an address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      if (w0_we) regs_q[w0_eff]  <= w0_data;
      if (w1_we) regs_q[w1_addr] <= w1_data;
    end
  end

  assign hazard    = busy_q[ra_addr] | busy_q[rb_addr];
  assign pend_full = full_q;
  assign pend_cnt  = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (default parameters).
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra_addr, rb_addr, w0_addr, ld_dst, w1_addr;
  logic [31:0] ra_data, rb_data, w0_data, w1_data;
  logic        w0_en, w0_link, ld_issue, w1_en;
  logic        hazard, pend_full;
  logic [2:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  reg_file_sb dut (
    .clk(clk), .rst(rst),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .w0_en(w0_en), .w0_link(w0_link), .w0_addr(w0_addr), .w0_data(w0_data),
    .ld_issue(ld_issue), .ld_dst(ld_dst),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .hazard(hazard), .pend_full(pend_full), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w0_en = 0; w0_link = 0; w1_en = 0; ld_issue = 0;
  endtask

  task automatic issue(input logic [4:0] dst);
    ld_issue = 1; ld_dst = dst;
    step();
    ld_issue = 0;
  endtask

  initial begin
    rst = 1; idle();
    ra_addr = 0; rb_addr = 0; w0_addr = 0; ld_dst = 0; w1_addr = 0;
    w0_data = 0; w1_data = 0;
    #12;
    check("rst_cnt", 64'(pend_cnt), 64'd0);
    check("rst_full", 64'(pend_full), 64'd0);
    check("rst_hazard", 64'(hazard), 64'd0);
    check("rst_ra", 64'(ra_data), 64'd0);
    rst = 0;
    step();

    // W0 write with same-cycle read bypass
    w0_en = 1; w0_addr = 3; w0_data = 32'hDEADBEEF; ra_addr = 3; #1;
    check("byp_w0", 64'(ra_data), 64'hDEADBEEF);
    step(); idle(); #1;
    check("stored_w0", 64'(ra_data), 64'hDEADBEEF);

    // W0/W1 collision: W1 wins in bypass and storage
    w0_en = 1; w0_addr = 7; w0_data = 32'h11;
    w1_en = 1; w1_addr = 7; w1_data = 32'h22; ra_addr = 7; #1;
    check("byp_w1_wins", 64'(ra_data), 64'h22);
    step(); idle(); #1;
    check("stored_w1_wins", 64'(ra_data), 64'h22);
    check("unbusy_ret_cnt", 64'(pend_cnt), 64'd0);

    // Link write ignores w0_addr
    w0_en = 1; w0_link = 1; w0_addr = 5; w0_data = 32'h40;
    step(); idle();
    ra_addr = 5; rb_addr = 31; #1;
    check("link_r31", 64'(rb_data), 64'h40);
    check("link_r5", 64'(ra_data), 64'd0);

    // Fill scoreboard to MAX_PEND
    issue(1); issue(2); issue(3);
    check("cnt3", 64'(pend_cnt), 64'd3);
    check("not_full3", 64'(pend_full), 64'd0);
    issue(4);
    check("cnt4", 64'(pend_cnt), 64'd4);
    check("full4", 64'(pend_full), 64'd1);
    ra_addr = 0; rb_addr = 2; #1;
    check("hazard_r2", 64'(hazard), 64'd1);
    issue(5);
    check("full_ignore_cnt", 64'(pend_cnt), 64'd4);
    ra_addr = 5; rb_addr = 0; #1;
    check("full_ignore_busy5", 64'(hazard), 64'd0);

    // Return reg 2: hazard holds until the edge
    ra_addr = 0; rb_addr = 2; w1_en = 1; w1_addr = 2; w1_data = 32'h99; #1;
    check("hazard_pre_edge", 64'(hazard), 64'd1);
    check("byp_w1_rb", 64'(rb_data), 64'h99);
    step(); idle(); #1;
    check("ret_cnt", 64'(pend_cnt), 64'd3);
    check("ret_full", 64'(pend_full), 64'd0);
    check("ret_hazard", 64'(hazard), 64'd0);
    check("ret_data", 64'(rb_data), 64'h99);

    // Free a slot, then same-cycle issue/return on reg 6
    w1_en = 1; w1_addr = 1; w1_data = 32'h1;
    step(); idle();
    check("ret1_cnt", 64'(pend_cnt), 64'd2);
    issue(6);
    check("iss6_cnt", 64'(pend_cnt), 64'd3);
    ld_issue = 1; ld_dst = 6; w1_en = 1; w1_addr = 6; w1_data = 32'h66;
    step(); idle();
    ra_addr = 6; rb_addr = 0; #1;
    check("same_cyc_busy6", 64'(hazard), 64'd1);
    check("same_cyc_cnt", 64'(pend_cnt), 64'd3);
    check("same_cyc_data", 64'(ra_data), 64'h66);
    w1_en = 1; w1_addr = 6; w1_data = 32'h67;
    step(); idle(); #1;
    check("ret6_cnt", 64'(pend_cnt), 64'd2);
    check("ret6_hazard", 64'(hazard), 64'd0);

    // Mid-run reset with loads pending on regs 3 and 4
    ra_addr = 3; rb_addr = 4; #1;
    check("pre_rst_hazard", 64'(hazard), 64'd1);
    rst = 1; #1;
    check("mid_rst_cnt", 64'(pend_cnt), 64'd0);
    check("mid_rst_hazard", 64'(hazard), 64'd0);
    check("mid_rst_ra", 64'(ra_data), 64'd0);
    rst = 0;
    step();
    w1_en = 1; w1_addr = 3; w1_data = 32'h77;
    step(); idle(); #1;
    check("stale_ret_data", 64'(ra_data), 64'h77);
    check("stale_ret_cnt", 64'(pend_cnt), 64'd0);

`ifdef RF_ZERO_REG_EN
    w0_en = 1; w0_addr = 0; w0_data = 32'h5; ra_addr = 0; #1;
    check("zero_byp", 64'(ra_data), 64'd0);
    step(); idle(); #1;
    check("zero_stored", 64'(ra_data), 64'd0);
    issue(0);
    check("zero_issue_cnt", 64'(pend_cnt), 64'd0);
    check("zero_issue_hazard", 64'(hazard), 64'd0);
`else
    w0_en = 1; w0_addr = 0; w0_data = 32'h5; ra_addr = 0;
    step(); idle(); #1;
    check("r0_ordinary", 64'(ra_data), 64'h5);
    issue(0);
    check("r0_issue_cnt", 64'(pend_cnt), 64'd1);
    check("r0_issue_hazard", 64'(hazard), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
